// File: rtl/timebase_scale_controller_pkg.sv
// timebase_scale_controller_pkg: scale tables, widths and FSM encoding shared by the timebase
package timebase_scale_controller_pkg;
  localparam int SCALE_COUNT = 6;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(SCALE_COUNT - 1);
  localparam int MS_PER_DIV [SCALE_COUNT] = '{1, 2, 5, 10, 20, 50};
  localparam logic [3:0] LABEL_TENS_TBL [SCALE_COUNT] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5};
  localparam logic [3:0] LABEL_ONES_TBL [SCALE_COUNT] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0};
  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;
  function automatic longint sample_period(longint clk_hz, longint samples, logic [IDX_W-1:0] idx);
    return clk_hz * MS_PER_DIV[idx] / (1000 * samples);
  endfunction
endpackage

// File: rtl/timebase_scale_controller_if.sv
// timebase_scale_controller_if: button/frame inputs and strobe/label outputs of the timebase
interface timebase_scale_controller_if;
  import timebase_scale_controller_pkg::*;
  logic BTN_UP;
  logic BTN_DOWN;
  logic FRAME_START;
  logic FREEZE;
  logic SAMPLE_STROBE;
  logic CAPTURE_RESTART;
  logic [IDX_W-1:0] SCALE_INDEX;
  logic SCALE_PENDING;
  logic [3:0] LABEL_TENS;
  logic [3:0] LABEL_ONES;
  logic LABEL_TENS_BLANK;
  modport master (
    output BTN_UP, BTN_DOWN, FRAME_START, FREEZE,
    input SAMPLE_STROBE, CAPTURE_RESTART, SCALE_INDEX, SCALE_PENDING, LABEL_TENS, LABEL_ONES, LABEL_TENS_BLANK
  );
  modport slave (
    input BTN_UP, BTN_DOWN, FRAME_START, FREEZE,
    output SAMPLE_STROBE, CAPTURE_RESTART, SCALE_INDEX, SCALE_PENDING, LABEL_TENS, LABEL_ONES, LABEL_TENS_BLANK
  );
endinterface

// File: rtl/timebase_sample_divider.sv
// timebase_sample_divider: free-running period divider producing a registered one-cycle strobe
module timebase_sample_divider #(
  parameter int CNT_W = 24
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic [CNT_W-1:0] period,
  input  logic restart,
  input  logic hold,
  output logic strobe
);
  logic [CNT_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == period - CNT_W'(1);
  always_ff @(posedge CLOCK)
    if (RESET || restart) begin
      cnt <= '0;
      strobe <= 1'b0;
    end else if (hold) begin
      strobe <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      strobe <= wrap;
    end
endmodule

// File: rtl/timebase_scale_controller.sv
// timebase_scale_controller: button-stepped ms/div scale, frame-aligned commit, sample strobe and label digits
module timebase_scale_controller
  import timebase_scale_controller_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 108_000_000,
  parameter int SAMPLES_PER_DIV = 128,
  parameter int RESET_SCALE = 5,
  parameter int CNT_W = 24
) (
  input logic CLOCK,
  input logic RESET,
  timebase_scale_controller_if.slave bus
);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_SCALE);
  if (RESET_SCALE < 0 || RESET_SCALE >= SCALE_COUNT) begin : g_bad_reset_scale
    $error("RESET_SCALE out of range");
  end
  logic [CNT_W-1:0] period_tbl [SCALE_COUNT];
  for (genvar i = 0; i < SCALE_COUNT; i++) begin : g_period
    localparam longint P = sample_period(CLK_FREQ_HZ, SAMPLES_PER_DIV, IDX_W'(i));
    if (P < 1 || P >= (longint'(1) << CNT_W)) begin : g_bad_period
      $error("sample period does not fit CNT_W");
    end
    assign period_tbl[i] = CNT_W'(P);
  end
  state_t state, state_nxt;
  logic up_q, down_q, up_edge, down_edge, apply;
  logic [IDX_W-1:0] target, target_nxt, index_nxt;
  assign up_edge = bus.BTN_UP & ~up_q;
  assign down_edge = bus.BTN_DOWN & ~down_q;
  always_comb begin
    target_nxt = (up_edge && !down_edge && target != MAX_IDX) ? target + IDX_W'(1)
               : (down_edge && !up_edge && target != '0) ? target - IDX_W'(1) : target;
    apply = state == ST_PENDING && bus.FRAME_START && target_nxt != bus.SCALE_INDEX;
    index_nxt = apply ? target_nxt : bus.SCALE_INDEX;
    state_nxt = apply ? ST_APPLY : (target_nxt != index_nxt) ? ST_PENDING : ST_IDLE;
  end
  // Edge history tracks the buttons even in reset so a held button cannot fake an edge on release.
  always_ff @(posedge CLOCK) begin
    up_q <= bus.BTN_UP;
    down_q <= bus.BTN_DOWN;
  end
  always_ff @(posedge CLOCK)
    if (RESET) begin
      state <= ST_IDLE;
      target <= RST_IDX;
      bus.SCALE_INDEX <= RST_IDX;
      bus.SCALE_PENDING <= 1'b0;
      bus.CAPTURE_RESTART <= 1'b0;
      bus.LABEL_TENS <= LABEL_TENS_TBL[RST_IDX];
      bus.LABEL_ONES <= LABEL_ONES_TBL[RST_IDX];
      bus.LABEL_TENS_BLANK <= LABEL_TENS_TBL[RST_IDX] == 4'd0;
    end else begin
      state <= state_nxt;
      target <= target_nxt;
      bus.SCALE_INDEX <= index_nxt;
      bus.SCALE_PENDING <= state_nxt == ST_PENDING;
      bus.CAPTURE_RESTART <= apply;
      bus.LABEL_TENS <= LABEL_TENS_TBL[index_nxt];
      bus.LABEL_ONES <= LABEL_ONES_TBL[index_nxt];
      bus.LABEL_TENS_BLANK <= LABEL_TENS_TBL[index_nxt] == 4'd0;
    end
  timebase_sample_divider #(.CNT_W(CNT_W)) u_divider (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .period(period_tbl[bus.SCALE_INDEX]),
    .restart(apply),
    .hold(bus.FREEZE),
    .strobe(bus.SAMPLE_STROBE)
  );
endmodule

// File: tb/tb_timebase_scale_controller.sv
// tb_timebase_scale_controller: directed stimulus with a strobe/restart scoreboard and level checks
module tb_timebase_scale_controller;
  typedef struct {
    bit kind;
    int cyc;
    logic [2:0] idx;
    logic [3:0] tens;
    logic [3:0] ones;
    logic blank;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int base = 0;
  int per = 6400;
  ev_t exp_q [$];
  ev_t e;
  logic [1:0] act;
  int per_tab [6] = '{128, 256, 640, 1280, 2560, 6400};
  logic [3:0] tens_tab [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5};
  logic [3:0] ones_tab [6] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0};
  timebase_scale_controller_if bus ();
  timebase_scale_controller #(
    .CLK_FREQ_HZ(1_280_000),
    .SAMPLES_PER_DIV(10),
    .RESET_SCALE(5),
    .CNT_W(24)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Scoreboard monitor: every strobe/restart must match the head of the expected queue.
  always @(negedge clk) begin
    act = {bus.SAMPLE_STROBE, bus.CAPTURE_RESTART};
    if (act != 2'b00) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d strobe/restart=%b, required none", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act != {~e.kind, e.kind} || cyc != e.cyc ||
            (e.kind && {bus.SCALE_INDEX, bus.LABEL_TENS, bus.LABEL_ONES, bus.LABEL_TENS_BLANK} !=
                       {e.idx, e.tens, e.ones, e.blank})) begin
          fails++;
          $display("FAIL event cyc=%0d strobe/restart=%b idx=%0d label=%0d%0d blank=%b, required cyc=%0d strobe/restart=%b idx=%0d label=%0d%0d blank=%b",
                   cyc, act, bus.SCALE_INDEX, bus.LABEL_TENS, bus.LABEL_ONES, bus.LABEL_TENS_BLANK,
                   e.cyc, {~e.kind, e.kind}, e.idx, e.tens, e.ones, e.blank);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      tests++;
      fails++;
      e = exp_q.pop_front();
      $display("FAIL missing_event cyc=%0d strobe/restart=00, required strobe/restart=%b", cyc, {~e.kind, e.kind});
    end
  end
  task automatic check(input string name, input int actual, input int required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask
  task automatic check_scale(input string name, input int idx, input int pend);
    check({name, "_index"}, int'(bus.SCALE_INDEX), idx);
    check({name, "_pending"}, int'(bus.SCALE_PENDING), pend);
    check({name, "_tens"}, int'(bus.LABEL_TENS), int'(tens_tab[idx]));
    check({name, "_ones"}, int'(bus.LABEL_ONES), int'(ones_tab[idx]));
    check({name, "_blank"}, int'(bus.LABEL_TENS_BLANK), int'(tens_tab[idx] == 4'd0));
  endtask
  // Advance one cycle, first recording the strobe the upcoming cycle should carry.
  task automatic tick();
    int c;
    c = cyc + 1;
    if (rst) begin
      base = c;
      per = 6400;
    end else if (bus.FREEZE) base++;
    else if (c > base && (c - base) % per == 0)
      exp_q.push_back('{kind: 1'b0, cyc: c, idx: 3'd0, tens: 4'd0, ones: 4'd0, blank: 1'b0});
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic press(input bit up, input bit down);
    bus.BTN_UP = up;
    bus.BTN_DOWN = down;
    tick();
    bus.BTN_UP = 1'b0;
    bus.BTN_DOWN = 1'b0;
    tick();
  endtask
  task automatic frame(input bit apply, input int idx);
    bus.FRAME_START = 1'b1;
    if (apply) begin
      exp_q.push_back('{kind: 1'b1, cyc: cyc + 1, idx: 3'(idx), tens: tens_tab[idx], ones: ones_tab[idx],
                        blank: tens_tab[idx] == 4'd0});
      base = cyc + 1;
      per = per_tab[idx];
    end
    tick();
    bus.FRAME_START = 1'b0;
  endtask
  initial begin
    bus.BTN_UP = 1'b0;
    bus.BTN_DOWN = 1'b0;
    bus.FRAME_START = 1'b0;
    bus.FREEZE = 1'b0;
    run(3);
    rst = 1'b0;
    check_scale("reset", 5, 0);
    check("reset_strobe", int'(bus.SAMPLE_STROBE), 0);
    check("reset_restart", int'(bus.CAPTURE_RESTART), 0);
    run(12810);
    press(1'b0, 1'b1);
    check_scale("down1", 5, 1);
    press(1'b0, 1'b1);
    check_scale("down2", 5, 1);
    frame(1'b1, 3);
    check_scale("apply_10ms", 3, 0);
    check("apply_restart", int'(bus.CAPTURE_RESTART), 1);
    run(2600);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    repeat (6) press(1'b0, 1'b1);
    check_scale("six_down", 5, 1);
    frame(1'b1, 0);
    check_scale("apply_1ms", 0, 0);
    run(400);
    bus.BTN_DOWN = 1'b1;
    tick();
    check("down_at_floor_pending", int'(bus.SCALE_PENDING), 0);
    bus.BTN_DOWN = 1'b0;
    tick();
    press(1'b1, 1'b0);
    check_scale("up_pending", 0, 1);
    press(1'b0, 1'b1);
    check_scale("back_to_committed", 0, 0);
    frame(1'b0, 0);
    check_scale("idle_frame", 0, 0);
    run(50);
    bus.FREEZE = 1'b1;
    run(1000);
    bus.FREEZE = 1'b0;
    run(400);
    press(1'b1, 1'b1);
    check_scale("both_edges", 0, 0);
    frame(1'b0, 0);
    press(1'b1, 1'b0);
    check_scale("pending_before_reset", 0, 1);
    rst = 1'b1;
    bus.FRAME_START = 1'b1;
    tick();
    rst = 1'b0;
    bus.FRAME_START = 1'b0;
    check_scale("reset_over_frame", 5, 0);
    check("reset_over_frame_restart", int'(bus.CAPTURE_RESTART), 0);
    run(20);
    frame(1'b0, 0);
    check_scale("post_reset_frame", 5, 0);
    run(6400);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
